// File: rtl/input_reg_ts_sequencer.sv
// Test-pulse sequencer: runs a burst of test pulses into the input latch and collects a sticky per-channel fail mask.
// Latency: start to done = 1 + SETTLE + N*(PULSE_LEN+WINDOW+1) + (N-1)*GAP + SETTLE cycles; all outputs registered.
// Backpressure: none; start is ignored while busy, abort short-circuits the burst to RELEASE.
module input_reg_ts_sequencer #(
  parameter int WIDTH     = 32,
  parameter int SETTLE    = 4,
  parameter int PULSE_LEN = 2,
  parameter int WINDOW    = 3,
  parameter int GAP       = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_pulses,
  input  logic [WIDTH-1:0] q_in,
  output logic             en_ts,
  output logic             test_pulse,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] fail_mask,
  output logic [CNT_W-1:0] pulses_done
);

  // Phase timer must hold the longest phase length minus one.
  localparam int M1    = (SETTLE > PULSE_LEN) ? SETTLE : PULSE_LEN;
  localparam int M2    = (WINDOW > GAP) ? WINDOW : GAP;
  localparam int TMAX  = (M1 > M2) ? M1 : M2;
  localparam int TIM_W = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FIRE, S_CAPTURE, S_CHECK, S_GAP, S_RELEASE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [TIM_W-1:0]   timer;
  logic [CNT_W-1:0]   target;
  logic [WIDTH-1:0]   seen;
  logic               tim_zero;
  logic               last_pulse;
  logic               accept;
  logic               en_ts_nxt;
  logic               test_pulse_nxt;
  logic               busy_nxt;
  logic               done_nxt;

  assign tim_zero   = (timer == '0);
  // Widened compare so the +1 can never wrap onto the target.
  assign last_pulse = (({1'b0, pulses_done} + (CNT_W+1)'(1)) == {1'b0, target});
  // A zero-length burst is treated as no request at all.
  assign accept     = (state == S_IDLE) && start && (n_pulses != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort is honoured in every active phase except CHECK, which finishes first.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_ARM;
      S_ARM:     if (abort) state_nxt = S_RELEASE;
                 else if (tim_zero) state_nxt = S_FIRE;
      S_FIRE:    if (abort) state_nxt = S_RELEASE;
                 else if (tim_zero) state_nxt = S_CAPTURE;
      S_CAPTURE: if (abort) state_nxt = S_RELEASE;
                 else if (tim_zero) state_nxt = S_CHECK;
      S_CHECK:   state_nxt = (abort || last_pulse) ? S_RELEASE : S_GAP;
      S_GAP:     if (abort) state_nxt = S_RELEASE;
                 else if (tim_zero) state_nxt = S_FIRE;
      S_RELEASE: if (tim_zero) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with the state they describe.
  always_comb begin
    en_ts_nxt      = 1'b0;
    test_pulse_nxt = 1'b0;
    busy_nxt       = (state_nxt != S_IDLE);
    done_nxt       = (state == S_RELEASE) && (state_nxt == S_IDLE);
    case (state_nxt)
      S_ARM, S_CAPTURE, S_CHECK, S_GAP: en_ts_nxt = 1'b1;
      S_FIRE: begin
        en_ts_nxt      = 1'b1;
        test_pulse_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register; reset drops en_ts asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_ts      <= 1'b0;
      test_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      en_ts      <= en_ts_nxt;
      test_pulse <= test_pulse_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // Phase timer: reloaded on every state change, counts down to zero within a phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        S_ARM:     timer <= TIM_W'(SETTLE - 1);
        S_FIRE:    timer <= TIM_W'(PULSE_LEN - 1);
        S_CAPTURE: timer <= TIM_W'(WINDOW - 1);
        S_GAP:     timer <= TIM_W'(GAP - 1);
        S_RELEASE: timer <= TIM_W'(SETTLE - 1);
        default:   timer <= '0;
      endcase
    end else if (!tim_zero) begin
      timer <= timer - TIM_W'(1);
    end
  end

  // Burst bookkeeping: latch target on accept, accumulate hits per pulse, fold misses into the sticky mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target      <= '0;
      seen        <= '0;
      fail_mask   <= '0;
      pulses_done <= '0;
    end else begin
      if (accept) begin
        target      <= n_pulses;
        fail_mask   <= '0;
        pulses_done <= '0;
      end
      if (state_nxt == S_FIRE && state != S_FIRE)
        seen <= '0;
      else if (state == S_CAPTURE)
        seen <= seen | q_in;
      if (state == S_CHECK) begin
        fail_mask <= fail_mask | ~seen;
        if (pulses_done != {CNT_W{1'b1}})
          pulses_done <= pulses_done + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_input_reg_ts_sequencer.sv
// Bench for input_reg_ts_sequencer: directed bursts, expected burst results queued at start.
// A monitor checks each done pulse against the queue plus pulse widths, spacing and release length.
// Direct checks cover reset values, ignored starts and reset in the middle of a burst.
module tb_input_reg_ts_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  n_pulses = 8'd0;
  logic [31:0] q_in = '1;
  logic        en_ts, test_pulse, busy, done;
  logic [31:0] fail_mask;
  logic [7:0]  pulses_done;

  input_reg_ts_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_pulses(n_pulses),
    .q_in(q_in), .en_ts(en_ts), .test_pulse(test_pulse), .busy(busy), .done(done),
    .fail_mask(fail_mask), .pulses_done(pulses_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] fm;
    int          pd;
    int          dcyc;
    int          rises;
    int          lastw;
  } exp_t;

  exp_t exp_q[$];
  int   sc = 0;

  // Latch model: channels in drop_mask stay silent on pulse drop_idx (0 = every pulse).
  logic [31:0] drop_mask = '0;
  int          drop_idx = 0;
  int          pidx = 0;
  logic        tp_s = 1'b0;
  always @(negedge clk) begin
    if (!busy) pidx = 0;
    else if (test_pulse && !tp_s) pidx++;
    tp_s = test_pulse;
    q_in = (drop_idx == 0 || drop_idx == pidx) ? ~drop_mask : 32'hFFFF_FFFF;
  end

  // Monitor: tracks test_pulse shape and en_ts release, scores each done against the queue.
  int   rises = 0, cur_w = 0, last_rise = 0, en_fall = 0;
  int   widths[$];
  logic tp_p = 1'b0, en_p = 1'b0, done_p = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      rises = 0; cur_w = 0; widths.delete();
      tp_p = 1'b0; en_p = 1'b0; done_p = 1'b0;
    end else begin
      if (test_pulse && !tp_p) begin
        rises++;
        if (rises > 1) chk("pulse_spacing", cyc - last_rise, 14);
        last_rise = cyc;
        cur_w = 1;
      end else if (test_pulse) begin
        cur_w++;
      end else if (tp_p) begin
        widths.push_back(cur_w);
      end
      if (!en_ts && en_p) en_fall = cyc;
      if (done) begin
        chk("done_one_cycle", done_p, 0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_done: done at cycle %0d, expected no burst end", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.dcyc);
          chk("fail_mask", fail_mask, e.fm);
          chk("pulses_done", pulses_done, e.pd);
          chk("pulse_count", rises, e.rises);
          chk("pulse_widths_seen", widths.size(), e.rises);
          for (int i = 0; i < widths.size(); i++)
            chk("pulse_width", widths[i], (i == widths.size() - 1) ? e.lastw : 2);
          chk("release_len", cyc - en_fall, 4);
          chk("busy_at_done", busy, 0);
          chk("en_ts_at_done", en_ts, 0);
        end
        rises = 0; widths.delete();
      end
      tp_p = test_pulse; en_p = en_ts; done_p = done;
    end
  end

  task automatic do_start(input int n, input logic ab);
    @(negedge clk);
    start = 1'b1; abort = ab; n_pulses = 8'(n);
    sc = cyc;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic expect_burst(input logic [31:0] fm, input int pd, input int lat, input int r, input int lw);
    exp_q.push_back('{fm, pd, sc + lat, r, lw});
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_en_ts", en_ts, 0);
    chk("rst_test_pulse", test_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail_mask", fail_mask, 0);
    chk("rst_pulses_done", pulses_done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single pulse, all channels respond
    drop_mask = '0; drop_idx = 0;
    do_start(1, 1'b0);
    expect_burst(32'h0, 1, 15, 1, 2);
    drain("drain_single");

    // start and abort together in IDLE: start wins
    do_start(1, 1'b1);
    expect_burst(32'h0, 1, 15, 1, 2);
    drain("drain_start_abort");

    // Three pulses, channel 5 dead; start and n_pulses change while busy are ignored
    drop_mask = 32'h0000_0020; drop_idx = 0;
    do_start(3, 1'b0);
    expect_burst(32'h0000_0020, 3, 43, 3, 2);
    wait_cyc(sc + 10);
    start = 1'b1; n_pulses = 8'd7;
    @(negedge clk);
    start = 1'b0;
    drain("drain_three");

    // Four pulses, channel 31 misses only pulse 2: sticky
    drop_mask = 32'h8000_0000; drop_idx = 2;
    do_start(4, 1'b0);
    expect_burst(32'h8000_0000, 4, 57, 4, 2);
    drain("drain_sticky");

    // Two pulses, no channel responds
    drop_mask = 32'hFFFF_FFFF; drop_idx = 0;
    do_start(2, 1'b0);
    expect_burst(32'hFFFF_FFFF, 2, 29, 2, 2);
    drain("drain_all_dead");

    // Abort in the first cycle of the second FIRE of a 5-pulse burst
    drop_mask = '0; drop_idx = 0;
    do_start(5, 1'b0);
    expect_burst(32'h0, 1, 24, 2, 1);
    wait_cyc(sc + 19);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain("drain_abort_fire");

    // Abort during CHECK: the check completes, then release
    do_start(3, 1'b0);
    expect_burst(32'h0, 1, 15, 1, 2);
    wait_cyc(sc + 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain("drain_abort_check");

    // start with n_pulses = 0 is ignored
    do_start(0, 1'b0);
    repeat (3) @(negedge clk);
    chk("zero_busy", busy, 0);
    chk("zero_en_ts", en_ts, 0);
    repeat (20) @(negedge clk);

    // Reset in CAPTURE of the second pulse
    drop_mask = 32'h0000_0020; drop_idx = 0;
    do_start(3, 1'b0);
    wait_cyc(sc + 21);
    chk("pre_rst_fail_mask", fail_mask, 32'h0000_0020);
    chk("pre_rst_pulses_done", pulses_done, 1);
    chk("pre_rst_en_ts", en_ts, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en_ts", en_ts, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fail_mask", fail_mask, 0);
    chk("mid_rst_pulses_done", pulses_done, 0);
    chk("mid_rst_test_pulse", test_pulse, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean burst after reset
    drop_mask = '0; drop_idx = 0;
    do_start(1, 1'b0);
    expect_burst(32'h0, 1, 15, 1, 2);
    drain("drain_after_rst");

    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
